stream_demux_1to2: RTL and testbench

- 1-to-2 registered stream demultiplexer; the inverse of the team's 2:1 select mux.
- Routes each word on a single valid/ready input stream to output 0 or output 1, as chosen by a select bit that travels with the word.
- Each output has a one-entry holding register, so one branch can stall without blocking words bound for the other.
- Per-branch transfer counters support debug and scoreboard checks.

---
 rtl/stream_demux_1to2.sv | 135 +++++++++++++
 tb/tb_stream_demux_1to2.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to2.sv
// Purpose : 1-to-2 registered stream demux; in_sel routes each word to out0 or out1.
// Latency : one cycle from input accept to outk_valid; no combinational data path.
// Backpres: per-branch one-entry holding register; a stalled branch only blocks words aimed at it.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake; in_sel picks the branch, in_data is the word
//   out0_valid/out0_ready     branch 0 handshake, out0_data is the held word
//   out1_valid/out1_ready     branch 1 handshake, out1_data is the held word
//   cnt0, cnt1                free-running (wrapping) count of words delivered per branch
module stream_demux_1to2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,

    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,

    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,

    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic              state0;
    logic              state1;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              out0_xfer;
    logic              out1_xfer;
    logic              slot0_free;
    logic              slot1_free;
    logic              in_xfer;
    logic              load0;
    logic              load1;

    // A slot can take a new word if it is empty, or if its current word
    // leaves this same cycle (drain-and-fill keeps 1 word/cycle per branch).
    assign out0_xfer  = (state0 == ST_FULL) & out0_ready;
    assign out1_xfer  = (state1 == ST_FULL) & out1_ready;
    assign slot0_free = (state0 == ST_EMPTY) | out0_xfer;
    assign slot1_free = (state1 == ST_EMPTY) | out1_xfer;

    // Only the selected branch decides in_ready, so a stall on the other
    // branch never blocks this word.
    assign in_ready = !rst & (in_sel ? slot1_free : slot0_free);
    assign in_xfer  = in_valid & in_ready;
    assign load0    = in_xfer & !in_sel;
    assign load1    = in_xfer &  in_sel;

    // Branch 0 holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state0 <= ST_EMPTY;
            hold0  <= '0;
        end else begin
            case (state0)
                ST_EMPTY: begin
                    if (load0) begin
                        state0 <= ST_FULL;
                        hold0  <= in_data;
                    end
                end
                ST_FULL: begin
                    if (load0) begin
                        hold0  <= in_data;
                    end else if (out0_xfer) begin
                        state0 <= ST_EMPTY;
                    end
                end
                default: state0 <= ST_EMPTY;
            endcase
        end
    end

    // Branch 1 holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state1 <= ST_EMPTY;
            hold1  <= '0;
        end else begin
            case (state1)
                ST_EMPTY: begin
                    if (load1) begin
                        state1 <= ST_FULL;
                        hold1  <= in_data;
                    end
                end
                ST_FULL: begin
                    if (load1) begin
                        hold1  <= in_data;
                    end else if (out1_xfer) begin
                        state1 <= ST_EMPTY;
                    end
                end
                default: state1 <= ST_EMPTY;
            endcase
        end
    end

    // Delivery counters wrap silently at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (out0_xfer) cnt0_q <= cnt0_q + 1'b1;
            if (out1_xfer) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign out0_valid = (state0 == ST_FULL);
    assign out1_valid = (state1 == ST_FULL);
    assign out0_data  = hold0;
    assign out1_data  = hold1;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Purpose : directed, table-driven bench for stream_demux_1to2.
// Latency : checks in_ready before each edge and registered outputs #1 after it.
// Backpres: exercises per-branch stalls, drain-and-fill, streaming and counter wrap.
module tb_stream_demux_1to2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int n_cmp;
    int n_fail;

    stream_demux_1to2 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       e_ir;   // in_ready before the edge
        logic       e0v;    // registered outputs after the edge
        logic [7:0] e0d;
        logic       e1v;
        logic [7:0] e1d;
        logic [7:0] ec0;
        logic [7:0] ec1;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic r0, logic r1,
                                logic e_ir, logic e0v, logic [7:0] e0d,
                                logic e1v, logic [7:0] e1d,
                                logic [7:0] ec0, logic [7:0] ec1);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
        t.e_ir = e_ir; t.e0v = e0v; t.e0d = e0d; t.e1v = e1v; t.e1d = e1d;
        t.ec0 = ec0; t.ec1 = ec1;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic check_outs(input string tag, input logic e0v, input logic [7:0] e0d,
                              input logic e1v, input logic [7:0] e1d,
                              input logic [7:0] ec0, input logic [7:0] ec1);
        check({tag, ".out0_valid"}, {31'd0, out0_valid}, {31'd0, e0v});
        check({tag, ".out0_data"},  {24'd0, out0_data},  {24'd0, e0d});
        check({tag, ".out1_valid"}, {31'd0, out1_valid}, {31'd0, e1v});
        check({tag, ".out1_data"},  {24'd0, out1_data},  {24'd0, e1d});
        check({tag, ".cnt0"},       {24'd0, cnt0},       {24'd0, ec0});
        check({tag, ".cnt1"},       {24'd0, cnt1},       {24'd0, ec1});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Routing, isolation, drain-and-fill and ready-while-empty, hand computed.
        //          v  s  d     r0 r1 | ir o0v o0d   o1v o1d   c0 c1
        tbl[0]  = mk(1, 0, 8'h11, 1, 1,  1, 1, 8'h11, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 8'h22, 1, 1,  1, 0, 8'h11, 1, 8'h22, 1, 0);
        tbl[2]  = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h11, 0, 8'h22, 1, 1);
        tbl[3]  = mk(1, 0, 8'h33, 0, 1,  1, 1, 8'h33, 0, 8'h22, 1, 1);
        tbl[4]  = mk(1, 0, 8'h44, 0, 1,  0, 1, 8'h33, 0, 8'h22, 1, 1);
        tbl[5]  = mk(1, 1, 8'h55, 0, 0,  1, 1, 8'h33, 1, 8'h55, 1, 1);
        tbl[6]  = mk(1, 0, 8'h44, 0, 1,  0, 1, 8'h33, 0, 8'h55, 1, 2);
        tbl[7]  = mk(1, 0, 8'h44, 1, 1,  1, 1, 8'h44, 0, 8'h55, 2, 2);
        tbl[8]  = mk(1, 0, 8'h66, 1, 1,  1, 1, 8'h66, 0, 8'h55, 3, 2);
        tbl[9]  = mk(1, 0, 8'h77, 1, 1,  1, 1, 8'h77, 0, 8'h55, 4, 2);
        tbl[10] = mk(0, 1, 8'hFF, 0, 1,  1, 1, 8'h77, 0, 8'h55, 4, 2);
        tbl[11] = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h77, 0, 8'h55, 5, 2);
        tbl[12] = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h77, 0, 8'h55, 5, 2);

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check_outs("rst", 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #2;
            check($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e0v, tbl[i].e0d, tbl[i].e1v,
                       tbl[i].e1d, tbl[i].ec0, tbl[i].ec1);
        end

        // Streaming: 16 back-to-back words on branch 1, cnt1 goes 2 -> 18.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, i[7:0], 1'b0, 1'b1);
            #2;
            check($sformatf("stream%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d.out1_valid", i), {31'd0, out1_valid}, 32'd1);
            check($sformatf("stream%0d.out1_data", i), {24'd0, out1_data}, i);
            check($sformatf("stream%0d.cnt1", i), {24'd0, cnt1}, 32'd2 + i);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("stream.end.out1_valid", {31'd0, out1_valid}, 32'd0);
        check("stream.end.cnt1", {24'd0, cnt1}, 32'd18);
        check("stream.end.cnt0", {24'd0, cnt0}, 32'd5);

        // Counter wrap: 256 more deliveries on out0, cnt0 5 -> 255 -> 0 -> 5.
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, j[7:0], 1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (j == 250) check("wrap.cnt0_255", {24'd0, cnt0}, 32'd255);
            if (j == 251) check("wrap.cnt0_0",   {24'd0, cnt0}, 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("wrap.end.cnt0", {24'd0, cnt0}, 32'd5);
        check("wrap.end.cnt1", {24'd0, cnt1}, 32'd18);
        check("wrap.end.out0_valid", {31'd0, out0_valid}, 32'd0);
        check("wrap.end.out0_data", {24'd0, out0_data}, 32'hFF);

        // Mid-stream reset with out0 holding 0xA5: asynchronous clear.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("arst.pre.out0_valid", {31'd0, out0_valid}, 32'd1);
        check("arst.pre.out0_data", {24'd0, out0_data}, 32'hA5);
        #2;
        rst = 1'b1;
        #1;
        check("arst.in_ready", {31'd0, in_ready}, 32'd0);
        check_outs("arst", 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0);
        drive(1'b1, 1'b1, 8'hBB, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("arst.hold.in_ready", {31'd0, in_ready}, 32'd0);
        check("arst.hold.out1_valid", {31'd0, out1_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        check("arst.post.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_outs("arst.post", 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
